// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared command encodings, state type and width constant for
//               the iterative divider (the multiplier reuses the encodings).
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Operand/result width of the HI/LO datapath
  localparam int WIDTH = 32;

  // DivCtrl / MulCtrl command encodings
  localparam logic [1:0] DIV_IDLE  = 2'b00;
  localparam logic [1:0] DIV_LOAD  = 2'b01;
  localparam logic [1:0] DIV_START = 2'b10;
  localparam logic [1:0] DIV_ACK   = 2'b11;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOADED = 2'b01,
    RUN    = 2'b10,
    DONE   = 2'b11
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder and subtracts the
//               divisor when it fits, producing one quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  // The shifted remainder is formed one bit wider so the compare is exact even
  // though the top bit is always zero while the remainder stays below d.
  assign q_bit  = ({r, q_msb} >= {1'b0, d});
  assign r_next = q_bit ? WIDTH'({r, q_msb} - {1'b0, d})
                        : {r[WIDTH-2:0], q_msb};

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative signed divider, one quotient bit per clock using a
//               restoring algorithm on operand magnitudes. Quotient goes to
//               Lo, remainder to Hi, with MIPS DIV sign rules.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clck,
  input  logic             reset,
  input  logic [1:0]       DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             DivZero,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  import div_pkg::*;

  localparam int            CW         = $clog2(ITER);
  localparam logic [CW-1:0] c_last_it  = CW'(ITER - 1);

  div_state_e       r_state;
  logic [WIDTH-1:0] r_a;      // latched dividend
  logic [WIDTH-1:0] r_b;      // latched divisor
  logic [WIDTH-1:0] r_q;      // dividend magnitude shifting out / quotient shifting in
  logic [WIDTH-1:0] r_r;      // partial remainder
  logic [WIDTH-1:0] r_d;      // divisor magnitude
  logic [CW-1:0]    r_cnt;
  logic             r_qneg;
  logic             r_rneg;

  logic [WIDTH-1:0] w_r_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r      (r_r),
    .q_msb  (r_q[WIDTH-1]),
    .d      (r_d),
    .r_next (w_r_next),
    .q_bit  (w_q_bit)
  );

  // Magnitudes are taken as unsigned, so the most negative value maps to itself
  assign w_a_mag   = r_a[WIDTH-1] ? -r_a : r_a;
  assign w_b_mag   = r_b[WIDTH-1] ? -r_b : r_b;
  assign w_q_final = {r_q[WIDTH-2:0], w_q_bit};

  // Control FSM and datapath registers; a load overrides every state
  always_ff @(posedge clck) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      DivZero <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else if (DivCtrl == DIV_LOAD) begin
      // Aborts any division in flight; Hi/Lo keep the last result
      r_a     <= A;
      r_b     <= B;
      DivZero <= (B == '0);
      Done    <= 1'b0;
      Busy    <= 1'b0;
      r_state <= LOADED;
    end else begin
      case (r_state)
        LOADED: begin
          // A zero divisor leaves the unit parked; control takes its exception path
          if (DivCtrl == DIV_START && !DivZero) begin
            r_q     <= w_a_mag;
            r_d     <= w_b_mag;
            r_r     <= '0;
            r_qneg  <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
            r_rneg  <= r_a[WIDTH-1];
            r_cnt   <= '0;
            Busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_r   <= w_r_next;
          r_q   <= w_q_final;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_last_it) begin
            // Negating a zero remainder yields zero, so no special case is needed
            Lo      <= r_qneg ? -w_q_final : w_q_final;
            Hi      <= r_rneg ? -w_r_next  : w_r_next;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (DivCtrl == DIV_ACK) begin
            Done    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
